// File: rtl/pwm_compare_nch.sv
// -----------------------------------------------------------------------------
// pwm_compare_nch
//   Multi-channel carrier/compare PWM generator with complementary gate
//   outputs, per-channel polarity, per-channel enable and shadowed
//   (double-buffered) controls.
//
//   Optional feature macro: PWM_COMPARE_NCH_DT_EN
//     defined   : per-channel dead-time FSM with down-counters between the
//                 A and B phases (dt_a / dt_b shadowed and used).
//     undefined : plain complementary outputs, dt_a / dt_b ignored.
//
// Parameters
//   NCH  number of complementary channel pairs (1..16)
//   CW   carrier / compare width
//   DTW  dead-time count width
//
// Ports
//   clk       system clock, all logic on the rising edge
//   reset     synchronous active-low reset
//   en        global PWM enable; while low all shadowed inputs track live
//   carrier   shared carrier count
//   cmp       per-channel compare, channel i at [i*CW +: CW]
//   dt_a      per-channel dead time before A turns on (clk cycles)
//   dt_b      per-channel dead time before B turns on (clk cycles)
//   pol_a     per-channel A polarity (1 = active-low)
//   pol_b     per-channel B polarity (1 = active-low)
//   ch_en     per-channel enable
//   load      shadow-update strobe (honoured while en=1)
//   load_ack  one-cycle pulse after a strobe was applied
//   pwm_a     A gate outputs (registered)
//   pwm_b     B gate outputs (registered)
// -----------------------------------------------------------------------------
module pwm_compare_nch #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int DTW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [CW-1:0]      carrier,
    input  logic [NCH*CW-1:0]  cmp,
    input  logic [NCH*DTW-1:0] dt_a,
    input  logic [NCH*DTW-1:0] dt_b,
    input  logic [NCH-1:0]     pol_a,
    input  logic [NCH-1:0]     pol_b,
    input  logic [NCH-1:0]     ch_en,
    input  logic               load,
    output logic               load_ack,
    output logic [NCH-1:0]     pwm_a,
    output logic [NCH-1:0]     pwm_b
);

    logic              w_upd;
    logic [NCH*CW-1:0] r_cmp_act;
    logic [NCH-1:0]    r_pol_a_act;
    logic [NCH-1:0]    r_pol_b_act;
    logic [NCH-1:0]    r_ch_en_act;
    logic [NCH-1:0]    r_raw;
    logic [NCH-1:0]    w_raw_nxt;
    logic [NCH-1:0]    w_pwm_a_nxt;
    logic [NCH-1:0]    w_pwm_b_nxt;
    logic [NCH-1:0]    r_pwm_a;
    logic [NCH-1:0]    r_pwm_b;
    logic              r_load_ack;

`ifdef PWM_COMPARE_NCH_DT_EN
    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_A_ON = 3'd1,
        ST_DT_B = 3'd2,
        ST_B_ON = 3'd3,
        ST_DT_A = 3'd4
    } state_t;

    localparam logic [DTW-1:0] DT_ZERO = {DTW{1'b0}};
    localparam logic [DTW-1:0] DT_ONE  = DTW'(1'b1);

    logic [NCH*DTW-1:0]        r_dt_a_act;
    logic [NCH*DTW-1:0]        r_dt_b_act;
    logic [NCH-1:0][2:0]       r_state;
    logic [NCH-1:0][2:0]       w_state_nxt;
    logic [NCH-1:0][DTW-1:0]   r_cnt;
    logic [NCH-1:0][DTW-1:0]   w_cnt_nxt;
`endif

    // While disabled the active set follows the inputs; while running only a strobe updates it.
    assign w_upd = ~en | load;

    // Active (shadow) control registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cmp_act   <= {(NCH*CW){1'b0}};
            r_pol_a_act <= {NCH{1'b0}};
            r_pol_b_act <= {NCH{1'b0}};
            r_ch_en_act <= {NCH{1'b0}};
`ifdef PWM_COMPARE_NCH_DT_EN
            r_dt_a_act  <= {(NCH*DTW){1'b0}};
            r_dt_b_act  <= {(NCH*DTW){1'b0}};
`endif
        end else if (w_upd) begin
            r_cmp_act   <= cmp;
            r_pol_a_act <= pol_a;
            r_pol_b_act <= pol_b;
            r_ch_en_act <= ch_en;
`ifdef PWM_COMPARE_NCH_DT_EN
            r_dt_a_act  <= dt_a;
            r_dt_b_act  <= dt_b;
`endif
        end else begin
            r_cmp_act   <= r_cmp_act;
            r_pol_a_act <= r_pol_a_act;
            r_pol_b_act <= r_pol_b_act;
            r_ch_en_act <= r_ch_en_act;
`ifdef PWM_COMPARE_NCH_DT_EN
            r_dt_a_act  <= r_dt_a_act;
            r_dt_b_act  <= r_dt_b_act;
`endif
        end
    end

    // Acknowledge pulse: a strobe only counts while the PWM is running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= en & load;
        end
    end

    // Unsigned carrier compare; cmp=0 never fires, cmp=max fires except at carrier=max.
    always_comb begin
        w_raw_nxt = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            w_raw_nxt[i] = en & r_ch_en_act[i] & (carrier < r_cmp_act[i*CW +: CW]);
        end
    end

    // Registered compare result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_raw <= {NCH{1'b0}};
        end else begin
            r_raw <= w_raw_nxt;
        end
    end

`ifdef PWM_COMPARE_NCH_DT_EN
    // Per-channel next state, dead-time count and output levels; outputs follow the next
    // state so the carrier-to-pin latency stays at two cycles.
    always_comb begin
        state_t         w_cur;
        state_t         w_nxt;
        logic [DTW-1:0] w_cnt;
        logic [DTW-1:0] w_dta;
        logic [DTW-1:0] w_dtb;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pwm_a_nxt = {NCH{1'b0}};
        w_pwm_b_nxt = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            w_cur = state_t'(r_state[i]);
            w_nxt = w_cur;
            w_cnt = r_cnt[i];
            w_dta = r_dt_a_act[i*DTW +: DTW];
            w_dtb = r_dt_b_act[i*DTW +: DTW];
            if (!en || !r_ch_en_act[i]) begin
                w_nxt = ST_OFF;
                w_cnt = DT_ZERO;
            end else begin
                case (w_cur)
                    ST_OFF: begin
                        w_nxt = r_raw[i] ? ST_A_ON : ST_B_ON;
                    end
                    ST_A_ON: begin
                        if (!r_raw[i]) begin
                            // Counter is loaded with dt-1 so DT_B lasts exactly dt cycles.
                            if (w_dtb == DT_ZERO) begin
                                w_nxt = ST_B_ON;
                            end else begin
                                w_nxt = ST_DT_B;
                                w_cnt = w_dtb - DT_ONE;
                            end
                        end else begin
                            w_nxt = ST_A_ON;
                        end
                    end
                    ST_DT_B: begin
                        if (r_raw[i]) begin
                            // Low pulse shorter than the dead time: fall back to A.
                            w_nxt = ST_A_ON;
                            w_cnt = DT_ZERO;
                        end else if (w_cnt == DT_ZERO) begin
                            w_nxt = ST_B_ON;
                        end else begin
                            w_cnt = w_cnt - DT_ONE;
                        end
                    end
                    ST_B_ON: begin
                        if (r_raw[i]) begin
                            if (w_dta == DT_ZERO) begin
                                w_nxt = ST_A_ON;
                            end else begin
                                w_nxt = ST_DT_A;
                                w_cnt = w_dta - DT_ONE;
                            end
                        end else begin
                            w_nxt = ST_B_ON;
                        end
                    end
                    ST_DT_A: begin
                        if (!r_raw[i]) begin
                            w_nxt = ST_B_ON;
                            w_cnt = DT_ZERO;
                        end else if (w_cnt == DT_ZERO) begin
                            w_nxt = ST_A_ON;
                        end else begin
                            w_cnt = w_cnt - DT_ONE;
                        end
                    end
                    default: begin
                        w_nxt = ST_OFF;
                        w_cnt = DT_ZERO;
                    end
                endcase
            end
            w_state_nxt[i] = w_nxt;
            w_cnt_nxt[i]   = w_cnt;
            w_pwm_a_nxt[i] = (w_nxt == ST_A_ON) ^ r_pol_a_act[i];
            w_pwm_b_nxt[i] = (w_nxt == ST_B_ON) ^ r_pol_b_act[i];
        end
    end

    // FSM state and dead-time counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= {(NCH*3){1'b0}};
            r_cnt   <= {(NCH*DTW){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
`else
    logic w_unused_dt;
    assign w_unused_dt = ^{dt_a, dt_b};

    // Plain complementary drive: B is only active while the channel is enabled.
    always_comb begin
        w_pwm_a_nxt = {NCH{1'b0}};
        w_pwm_b_nxt = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            w_pwm_a_nxt[i] = r_raw[i] ^ r_pol_a_act[i];
            w_pwm_b_nxt[i] = (~r_raw[i] & en & r_ch_en_act[i]) ^ r_pol_b_act[i];
        end
    end
`endif

    // Registered gate outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pwm_a <= {NCH{1'b0}};
            r_pwm_b <= {NCH{1'b0}};
        end else begin
            r_pwm_a <= w_pwm_a_nxt;
            r_pwm_b <= w_pwm_b_nxt;
        end
    end

    assign pwm_a    = r_pwm_a;
    assign pwm_b    = r_pwm_b;
    assign load_ack = r_load_ack;

endmodule
